// File: rtl/s2p_frame_ctrl_if.sv
// Frame output bus between the serial front-end frame controller and the adaptive-filter core.
interface s2p_frame_ctrl_if #(
  parameter int W = 14
) ();
  // valid/ready: a frame transfers on every clk edge where frame_valid and frame_ready are both
  // high; while frame_valid is high and frame_ready low, the source holds all data fields stable.
  logic         frame_valid;
  logic         frame_ready;
  logic [W-1:0] buffer_2;
  logic [W-1:0] buffer_3;
  logic [W-1:0] reff;

  modport master (output frame_valid, buffer_2, buffer_3, reff, input frame_ready);
  modport slave  (input frame_valid, buffer_2, buffer_3, reff, output frame_ready);
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Oversampled SPI-style word receiver plus header/slot framer feeding a valid/ready frame output.
module s2p_frame_ctrl #(
  parameter int           W           = 14,
  parameter logic [W-1:0] HEADER      = W'(14'h0FFF),
  parameter int           TIMEOUT     = 4096,
  parameter int           SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mosi,
  input  logic             sck,
  input  logic             cs,
  s2p_frame_ctrl_if.master fo,
  output logic             bit_err,
  output logic             timeout,
  output logic             overrun,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       dbg_state
);

  localparam int BCW = $clog2(W + 2);
  localparam int GCW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(W);
  localparam logic [BCW-1:0] BC_SAT  = BCW'(W + 1);
  localparam logic [GCW-1:0] GAP_MAX = GCW'(TIMEOUT);

  typedef enum logic [1:0] {HUNT = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] mosi_sr, sck_sr, cs_sr;
  logic                   sck_d, cs_d;
  logic                   mosi_s, sck_s, cs_s;
  logic                   sck_rise, cs_rise, cs_fall;
  logic [W-1:0]           shift_q;
  logic [BCW-1:0]         bit_cnt;
  logic [GCW-1:0]         gap_cnt;
  logic [W-1:0]           hold_a;
  logic                   word_end, word_good;
  logic                   lat_a, frame_done, to_hit;
  logic                   xfer;
  logic [W-1:0]           reff_nx;

  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_s    = sck_sr[SYNC_STAGES-1];
  assign cs_s     = cs_sr[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign word_end  = cs_rise;
  assign word_good = word_end && (bit_cnt == BC_FULL);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sr <= '0;
      sck_sr  <= '0;
      cs_sr   <= '0;
      sck_d   <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs};
      sck_d   <= sck_s;
      cs_d    <= cs_s;
    end
  end

  // The bit counter saturates one past W so an over-long word can never alias back to W.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (cs_rise || cs_fall) begin
      bit_cnt <= '0;
      if (cs_fall) shift_q <= '0;
    end else if (sck_rise && !cs_s) begin
      shift_q <= {shift_q[W-2:0], mosi_s};
      if (bit_cnt != BC_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == HUNT || word_end) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  // A word arriving in the same cycle the gap limit is reached wins over the timeout.
  always_comb begin
    state_nx   = state;
    lat_a      = 1'b0;
    frame_done = 1'b0;
    to_hit     = 1'b0;
    case (state)
      HUNT: begin
        if (word_good && shift_q == HEADER) state_nx = SLOT1;
      end
      SLOT1: begin
        if (word_end) begin
          if (word_good) begin
            lat_a    = 1'b1;
            state_nx = SLOT2;
          end else begin
            state_nx = HUNT;
          end
        end else if (gap_cnt == GAP_MAX) begin
          to_hit   = 1'b1;
          state_nx = HUNT;
        end
      end
      SLOT2: begin
        if (word_end) begin
          frame_done = word_good;
          state_nx   = HUNT;
        end else if (gap_cnt == GAP_MAX) begin
          to_hit   = 1'b1;
          state_nx = HUNT;
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_a  <= '0;
      bit_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (lat_a) hold_a <= shift_q;
      bit_err <= word_end && !word_good;
      timeout <= to_hit;
    end
  end

  // The slot-2 word is still in the shift register on frame_done, so it feeds the outputs directly.
  assign xfer    = fo.frame_valid && fo.frame_ready;
  assign reff_nx = {1'b0, hold_a[W-1:1]} + {1'b0, shift_q[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fo.frame_valid <= 1'b0;
      fo.buffer_2    <= '0;
      fo.buffer_3    <= '0;
      fo.reff        <= '0;
      overrun        <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      if (frame_done) begin
        if (!fo.frame_valid || fo.frame_ready) begin
          fo.buffer_2    <= hold_a;
          fo.buffer_3    <= shift_q;
          fo.reff        <= reff_nx;
          fo.frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        fo.frame_valid <= 1'b0;
      end
      if (xfer) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: doc/s2p_frame_ctrl.md
# s2p_frame_ctrl

Single-clock frame controller for the serial AD front end. It oversamples the SPI-style link (mosi, sck, cs) in the system clock domain and assembles 14-bit words. It then sequences the header / channel-2 / channel-3 slot order and hands each complete frame, including its reference average, to the adaptive-filter core over a valid/ready handshake. Framing errors, timeouts and overruns are detected, flagged and recovered from without a reset.

## Interface
- W, 14, sample and word width in bits
- HEADER, 14'h0FFF, header word that opens a frame
- TIMEOUT, 4096, maximum clk cycles between word ends inside a frame (≥ 2)
- SYNC_STAGES, 2, synchronizer depth on mosi/sck/cs (≥ 2)

- clk  in  1  system clock; every flop is on its rising edge
- rst  in  1  synchronous, active-high reset
- mosi  in  1  serial data, async to clk
- sck  in  1  serial clock, async to clk; data sampled on its rising edge
- cs  in  1  word strobe, async to clk; low during a word, rising edge = word end
- frame_ready  in  1  downstream accepts the frame
- frame_valid  out  1  frame held on outputs
- buffer_2  out  W  channel-2 sample (slot 1)
- buffer_3  out  W  channel-3 sample (slot 2)
- reff  out  W  (buffer_2>>1) + (buffer_3>>1)
- bit_err  out  1  one-cycle pulse: word ended with bit count ≠ W
- timeout  out  1  one-cycle pulse: in-frame word gap exceeded TIMEOUT
- overrun  out  1  sticky: a frame completed while frame_valid was high and not accepted; cleared only by rst
- frame_cnt  out  16  count of accepted frames; wraps 0xFFFF→0

## Operation
- mosi, sck and cs each pass through SYNC_STAGES flops and are named *_s. Rising edges are detected against a one-cycle-delayed copy.
- sck_s rise with cs_s low: shift register ← {shift[W-2:0], mosi_s}. The bit counter increments and saturates at W+1.
- cs_s rise: word_end for that cycle. The bit counter clears the same cycle. A cs_s fall also clears the bit counter and the shift register.
- A word is good when bit count == W at word_end. Otherwise bit_err pulses, the word is discarded and the FSM goes to HUNT.
- FSM states and transitions:
  - HUNT: a good word equal to HEADER → SLOT1. Anything else stays in HUNT silently.
  - SLOT1: a good word is latched into hold_a → SLOT2.
  - SLOT2: a good word is latched into hold_b → HUNT, and frame_done pulses.
- In SLOT1/SLOT2 the gap counter counts cycles since the last word_end. When it reaches TIMEOUT, timeout pulses and the FSM goes to HUNT. The gap counter resets on every word_end and in HUNT.
- A header value arriving in SLOT1/SLOT2 is treated as data, not as a resync.
- Output stage, on frame_done:
  - frame_valid low, or frame_valid and frame_ready both high in the same cycle: buffer_2 ← hold_a, buffer_3 ← hold_b, reff ← (hold_a>>1)+(hold_b>>1), frame_valid ← 1.
  - frame_valid high and frame_ready low: the new frame is dropped, the held frame stays unchanged, and overrun ← 1.
- Handshake: a transfer occurs in a cycle where frame_valid and frame_ready are both high. frame_cnt increments on each transfer. With no frame_done in that cycle, frame_valid ← 0. buffer_2, buffer_3 and reff hold their last values after the transfer.
- Arithmetic: reff is the sum of two (W-1)-bit operands, so its maximum is 2·(2^(W-1)−1) = 16382 for W=14. It never overflows W bits, so no truncation is needed.

## Timing
- Reset values: every output is 0, FSM = HUNT, and all counters, holds, the shift register and synchronizer flops are 0.
- Latency, async cs rise → word_end: SYNC_STAGES+1 clk.
- Latency, word_end of slot 2 → frame_valid high: 1 clk. Output data is valid in the same cycle as frame_valid.
- Serial rate limit: sck high and low phases must each be ≥ SYNC_STAGES+1 clk. Behaviour is undefined beyond this limit.
- bit_err and timeout last exactly 1 clk. They are mutually exclusive, because timeout resets the gap counter.
- Simultaneous frame_done and transfer: the new frame is loaded, frame_valid stays 1, frame_cnt increments and there is no overrun.
- rst mid-frame or mid-handshake: the next cycle is in the reset state. A partial frame is lost and frame_cnt is not incremented.

## Test plan
- Nominal: send 0x0FFF, 0x1234, 0x0ABC with frame_ready=1 → frame_valid pulses 1 clk; buffer_2=0x1234, buffer_3=0x0ABC, reff=0x091A+0x055E=0x0E78; frame_cnt=1.
- Hunt/resync: send 0x0001, 0x0FFF, 0x3FFF, 0x3FFF → the first word is ignored; a single frame with reff=0x1FFF+0x1FFF=0x3FFE.
- Bit error: header, then a 13-bit word → bit_err 1 clk, no frame. Then send header, 0x0002, 0x0004 → reff=0x0003.
- Timeout: header, then cs idle for TIMEOUT clk → timeout pulses once, FSM returns to HUNT, and a later full frame is delivered normally.
- Backpressure: hold frame_ready=0 and send two frames (A=0x0100/0x0200, B=0x0300/0x0400) → outputs stay at frame A and overrun=1. Then raise frame_ready → frame_cnt=1 and frame_valid drops.
- Reset mid-frame: assert rst for 1 clk after the header and slot 1 → all outputs 0. The next full frame 0x0FFF, 0x0010, 0x0020 gives reff=0x0018.
